// File: rtl/sound_scheduler_if.sv
// Bundles the sound request inputs and the tone-generator outputs of the
// sound scheduler. The scheduler sits on the slave side; whoever issues
// requests and consumes the tone parameters sits on the master side.
// Requests are single-cycle pulses with no ready/ack: the scheduler samples
// them every rising edge and either accepts them or drops them on the spot.
interface sound_scheduler_if;
  logic        chomp;
  logic        eatghost;
  logic        death;
  logic        mute;
  logic        tone_en;
  logic [14:0] half_period;
  logic [23:0] amplitude;
  logic [1:0]  active_id;
  logic        done;
  logic [1:0]  state_dbg;

  modport master (
    output chomp, eatghost, death, mute,
    input  tone_en, half_period, amplitude, active_id, done, state_dbg
  );

  modport slave (
    input  chomp, eatghost, death, mute,
    output tone_en, half_period, amplitude, active_id, done, state_dbg
  );
endinterface

// File: rtl/sound_scheduler.sv
// Plays short note sequences (chomp / eatghost / death) for a square-wave
// tone generator. Higher sound ids preempt lower ones, the same id restarts,
// mute and reset silence everything. All outputs come straight from flops.
module sound_scheduler #(
  parameter int NOTE_CYCLES = 3125000,
  parameter int GAP_CYCLES  = 250000
) (
  input logic               CLOCK_50,
  input logic               reset,
  sound_scheduler_if.slave  sif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int CNT_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  // Half-period of note idx within sound id.
  function automatic logic [14:0] note_hp(input logic [1:0] id, input logic [2:0] idx);
    logic [14:0] hp;
    hp = '0;
    case (id)
      2'd1: hp = 15'd7102;
      2'd2: begin
        case (idx[1:0])
          2'd0:    hp = 15'd14204;
          2'd1:    hp = 15'd10638;
          2'd2:    hp = 15'd8448;
          default: hp = 15'd7102;
        endcase
      end
      2'd3: begin
        case (idx)
          3'd0:    hp = 15'd7102;
          3'd1:    hp = 15'd7970;
          3'd2:    hp = 15'd8948;
          3'd3:    hp = 15'd10043;
          3'd4:    hp = 15'd11272;
          3'd5:    hp = 15'd12652;
          3'd6:    hp = 15'd14204;
          default: hp = 15'd15944;
        endcase
      end
      default: hp = '0;
    endcase
    return hp;
  endfunction

  // Amplitude is fixed for the whole sound.
  function automatic logic [23:0] note_amp(input logic [1:0] id);
    logic [23:0] a;
    case (id)
      2'd1:    a = 24'd40000;
      2'd2:    a = 24'd60000;
      2'd3:    a = 24'd80000;
      default: a = '0;
    endcase
    return a;
  endfunction

  // Index of the final note: death has 8 notes, the others 4.
  function automatic logic [2:0] last_idx(input logic [1:0] id);
    return (id == 2'd3) ? 3'd7 : 3'd3;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tone_en_q, tone_en_d;
  logic [14:0]      hp_q, hp_d;
  logic [23:0]      amp_q, amp_d;
  logic [1:0]       id_q, id_d;
  logic             done_q, done_d;

  logic [1:0] req_id;
  logic       accept;

  // Resolve simultaneous pulses to the highest id and decide acceptance.
  always_comb begin
    req_id = 2'd0;
    if (sif.death)         req_id = 2'd3;
    else if (sif.eatghost) req_id = 2'd2;
    else if (sif.chomp)    req_id = 2'd1;
    accept = !sif.mute && (req_id != 2'd0) && (req_id >= id_q);
  end

  // Next-state and next-output computation; a request beats natural completion.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tone_en_d = tone_en_q;
    hp_d      = hp_q;
    amp_d     = amp_q;
    id_d      = id_q;
    done_d    = 1'b0;
    if (sif.mute) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      cnt_d     = '0;
      tone_en_d = 1'b0;
      hp_d      = '0;
      amp_d     = '0;
      id_d      = '0;
    end else if (accept) begin
      state_d   = S_PLAY;
      idx_d     = '0;
      cnt_d     = '0;
      tone_en_d = 1'b1;
      hp_d      = note_hp(req_id, 3'd0);
      amp_d     = note_amp(req_id);
      id_d      = req_id;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (cnt_q == NOTE_LAST) begin
            cnt_d     = '0;
            tone_en_d = 1'b0;
            if (idx_q == last_idx(id_q)) begin
              state_d = S_IDLE;
              idx_d   = '0;
              hp_d    = '0;
              amp_d   = '0;
              id_d    = '0;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d     = '0;
            state_d   = S_PLAY;
            idx_d     = idx_q + 3'd1;
            tone_en_d = 1'b1;
            hp_d      = note_hp(id_q, idx_q + 3'd1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      tone_en_q <= 1'b0;
      hp_q      <= '0;
      amp_q     <= '0;
      id_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tone_en_q <= tone_en_d;
      hp_q      <= hp_d;
      amp_q     <= amp_d;
      id_q      <= id_d;
      done_q    <= done_d;
    end
  end

  assign sif.tone_en     = tone_en_q;
  assign sif.half_period = hp_q;
  assign sif.amplitude   = amp_q;
  assign sif.active_id   = id_q;
  assign sif.done        = done_q;
  assign sif.state_dbg   = state_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler with short notes. The reference model tracks only
// the playing sound id and the cycles elapsed since it started; expected
// outputs are derived from that by division into note+gap periods.
module tb_sound_scheduler;

  localparam int NOTE = 8;
  localparam int GAP  = 2;
  localparam int PER  = NOTE + GAP;

  // clock / reset
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sound_scheduler_if sif();

  sound_scheduler #(.NOTE_CYCLES(NOTE), .GAP_CYCLES(GAP)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .sif      (sif)
  );

  // reference tables
  int hp_tbl [3][8] = '{
    '{7102, 7102, 7102, 7102, 0, 0, 0, 0},
    '{14204, 10638, 8448, 7102, 0, 0, 0, 0},
    '{7102, 7970, 8948, 10043, 11272, 12652, 14204, 15944}
  };
  int amp_tbl [3] = '{40000, 60000, 80000};

  // reference model state
  int m_id;
  int m_e;
  bit m_done;

  int checks;
  int errors;
  logic [42:0] exp_q[$];

  function automatic int n_notes(input int id);
    return (id == 3) ? 8 : 4;
  endfunction

  function automatic logic [42:0] model_out(input int id, input int e, input bit d);
    logic        tone;
    logic [14:0] hp;
    logic [23:0] amp;
    logic [1:0]  aid;
    if (id == 0) return {1'b0, 15'd0, 24'd0, 2'd0, d};
    tone = ((e % PER) < NOTE);
    hp   = 15'(hp_tbl[id-1][e / PER]);
    amp  = 24'(amp_tbl[id-1]);
    aid  = 2'(id);
    return {tone, hp, amp, aid, d};
  endfunction

  // one clock edge of the model
  task automatic model_edge(input bit rc, input bit re, input bit rd, input bit mu, input bit r);
    int req;
    req = rd ? 3 : (re ? 2 : (rc ? 1 : 0));
    m_done = 1'b0;
    if (r || mu) begin
      m_id = 0;
      m_e  = 0;
    end else if (req != 0 && req >= m_id) begin
      m_id = req;
      m_e  = 0;
    end else if (m_id != 0) begin
      m_e++;
      if (m_e == n_notes(m_id) * PER - GAP) begin
        m_id   = 0;
        m_e    = 0;
        m_done = 1'b1;
      end
    end
  endtask

  // driver: apply one cycle of inputs and log the expected response
  task automatic step(input bit rc, input bit re, input bit rd, input bit mu, input bit r);
    @(negedge clk);
    sif.chomp    = rc;
    sif.eatghost = re;
    sif.death    = rd;
    sif.mute     = mu;
    rst          = r;
    model_edge(rc, re, rd, mu, r);
    exp_q.push_back(model_out(m_id, m_e, m_done));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // monitor / scoreboard
  initial begin
    logic [42:0] exp;
    logic [42:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {sif.tone_en, sif.half_period, sif.amplitude, sif.active_id, sif.done};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL outputs t=%0t got tone=%0d hp=%0d amp=%0d id=%0d done=%0d expected tone=%0d hp=%0d amp=%0d id=%0d done=%0d",
                   $time, act[42], act[41:27], act[26:3], act[2:1], act[0],
                   exp[42], exp[41:27], exp[26:3], exp[2:1], exp[0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    bit mute_lvl;
    checks       = 0;
    errors       = 0;
    m_id         = 0;
    m_e          = 0;
    m_done       = 1'b0;
    rst          = 1'b1;
    sif.chomp    = 1'b0;
    sif.eatghost = 1'b0;
    sif.death    = 1'b0;
    sif.mute     = 1'b0;

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // chomp from idle, full sequence with done
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(45);

    // chomp preempted by eatghost three cycles later
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(45);

    // death ignores a later chomp
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(80);

    // all three at once
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(85);

    // mute mid-eatghost, chomp while muted
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(12);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);

    // reset in the first gap of death, then chomp plays normally
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(45);

    // restart in the final cycle of a sound: no done
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(37);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(45);

    // randomized traffic
    mute_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 79) == 0) mute_lvl = ~mute_lvl;
      step($urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 69) == 0, mute_lvl, $urandom_range(0, 399) == 0);
    end
    idle(100);

    // drain the scoreboard with a bounded wait
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
